// File: rtl/syn_pipe_if_id.sv
// IF/ID pipeline register: captures fetch-stage pc_4 and instruction for decode,
// with halt freeze, flush bubbles, stall hold and saturating debug counters.
module syn_pipe_if_id #(
  parameter int          AddrBit = 10,
  parameter int          CntBit  = 16,
  parameter logic [31:0] NopInst = 32'h0000_0000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic               stall,
  input  logic               flush,
  input  logic               halt,
  input  logic [AddrBit-1:0] pc_4_in,
  input  logic [31:0]        inst_in,
  output logic [AddrBit-1:0] pc_4_out,
  output logic [31:0]        inst_out,
  output logic               valid_out,
  output logic               halted_out,
  output logic [CntBit-1:0]  stall_cnt,
  output logic [CntBit-1:0]  flush_cnt
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    RUN   = 2'd1,
    HALT  = 2'd2
  } state_e;

  localparam logic [CntBit-1:0] CntMax = '1;

  state_e             state_q, state_d;
  logic [AddrBit-1:0] pc_4_q, pc_4_d;
  logic [31:0]        inst_q, inst_d;
  logic               valid_q, valid_d;
  logic               halted_q, halted_d;
  logic [CntBit-1:0]  stall_cnt_q, stall_cnt_d;
  logic [CntBit-1:0]  flush_cnt_q, flush_cnt_d;

  // Priority halt > flush > stall > load; HALT absorbs everything until reset.
  always_comb begin
    state_d     = state_q;
    pc_4_d      = pc_4_q;
    inst_d      = inst_q;
    valid_d     = valid_q;
    halted_d    = halted_q;
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (en && (state_q != HALT)) begin
      if (halt) begin
        state_d  = HALT;
        halted_d = 1'b1;
      end else if (flush) begin
        pc_4_d  = '0;
        inst_d  = NopInst;
        valid_d = 1'b0;
        if (flush_cnt_q != CntMax) begin
          flush_cnt_d = flush_cnt_q + 1'b1;
        end
      end else if (stall) begin
        if (stall_cnt_q != CntMax) begin
          stall_cnt_d = stall_cnt_q + 1'b1;
        end
      end else begin
        state_d = RUN;
        pc_4_d  = pc_4_in;
        inst_d  = inst_in;
        valid_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= EMPTY;
      pc_4_q      <= '0;
      inst_q      <= NopInst;
      valid_q     <= 1'b0;
      halted_q    <= 1'b0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      pc_4_q      <= pc_4_d;
      inst_q      <= inst_d;
      valid_q     <= valid_d;
      halted_q    <= halted_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign pc_4_out   = pc_4_q;
  assign inst_out   = inst_q;
  assign valid_out  = valid_q;
  assign halted_out = halted_q;
  assign stall_cnt  = stall_cnt_q;
  assign flush_cnt  = flush_cnt_q;

endmodule

// File: tb/tb_syn_pipe_if_id.sv
// Self-checking bench for syn_pipe_if_id: table-driven vectors through a
// scoreboard queue, plus hand sequences for reset, EMPTY-state and saturation cases.
module tb_syn_pipe_if_id;

  typedef struct {
    logic [9:0]  pc;
    logic [31:0] inst;
    logic        valid;
    logic        halted;
    logic [15:0] scnt;
    logic [15:0] fcnt;
    string       name;
  } exp_t;

  typedef struct {
    logic        en;
    logic        stall;
    logic        flush;
    logic        halt;
    logic [9:0]  pc;
    logic [31:0] inst;
    exp_t        exp;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        en, stall, flush, halt;
  logic [9:0]  pc_4_in;
  logic [31:0] inst_in;
  logic [9:0]  pc_4_out;
  logic [31:0] inst_out;
  logic        valid_out, halted_out;
  logic [15:0] stall_cnt, flush_cnt;

  logic        en4, stall4, flush4, halt4;
  logic [9:0]  pc_4_in4;
  logic [31:0] inst_in4;
  logic [9:0]  pc_4_out4;
  logic [31:0] inst_out4;
  logic        valid_out4, halted_out4;
  logic [3:0]  stall_cnt4, flush_cnt4;

  int   pass_cnt = 0;
  int   total_cnt = 0;
  exp_t sb[$];
  vec_t vecs[$];

  always #5 clk = ~clk;

  syn_pipe_if_id dut (
    .clk(clk), .rst(rst), .en(en), .stall(stall), .flush(flush), .halt(halt),
    .pc_4_in(pc_4_in), .inst_in(inst_in), .pc_4_out(pc_4_out), .inst_out(inst_out),
    .valid_out(valid_out), .halted_out(halted_out),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  syn_pipe_if_id #(.CntBit(4)) dut4 (
    .clk(clk), .rst(rst), .en(en4), .stall(stall4), .flush(flush4), .halt(halt4),
    .pc_4_in(pc_4_in4), .inst_in(inst_in4), .pc_4_out(pc_4_out4), .inst_out(inst_out4),
    .valid_out(valid_out4), .halted_out(halted_out4),
    .stall_cnt(stall_cnt4), .flush_cnt(flush_cnt4)
  );

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic exp_t mkExp(input logic [9:0] pc, input logic [31:0] inst,
                                 input logic valid, input logic halted,
                                 input logic [15:0] scnt, input logic [15:0] fcnt,
                                 input string name);
    exp_t e;
    e.pc = pc; e.inst = inst; e.valid = valid; e.halted = halted;
    e.scnt = scnt; e.fcnt = fcnt; e.name = name;
    return e;
  endfunction

  function automatic vec_t mkVec(input logic e, input logic s, input logic f, input logic h,
                                 input logic [9:0] pc, input logic [31:0] inst, input exp_t x);
    vec_t v;
    v.en = e; v.stall = s; v.flush = f; v.halt = h; v.pc = pc; v.inst = inst; v.exp = x;
    return v;
  endfunction

  task automatic checkValue(input string name, input logic [31:0] act, input logic [31:0] req);
    total_cnt++;
    if (act === req) pass_cnt++;
    else $display("[TB] FAIL %s: got %h expected %h", name, act, req);
  endtask

  // Drive on the falling edge and record what the next rising edge should produce.
  task automatic applyStimulus(input vec_t v);
    @(negedge clk);
    en = v.en; stall = v.stall; flush = v.flush; halt = v.halt;
    pc_4_in = v.pc; inst_in = v.inst;
    sb.push_back(v.exp);
  endtask

  task automatic checkOutput();
    exp_t e;
    if (sb.size() == 0) begin
      checkValue("scoreboard_empty", 32'd1, 32'd0);
      return;
    end
    e = sb.pop_front();
    checkValue({e.name, ".pc_4_out"},   {22'd0, pc_4_out},  {22'd0, e.pc});
    checkValue({e.name, ".inst_out"},   inst_out,           e.inst);
    checkValue({e.name, ".valid_out"},  {31'd0, valid_out}, {31'd0, e.valid});
    checkValue({e.name, ".halted_out"}, {31'd0, halted_out},{31'd0, e.halted});
    checkValue({e.name, ".stall_cnt"},  {16'd0, stall_cnt}, {16'd0, e.scnt});
    checkValue({e.name, ".flush_cnt"},  {16'd0, flush_cnt}, {16'd0, e.fcnt});
  endtask

  task automatic runStep(input vec_t v);
    applyStimulus(v);
    @(posedge clk);
    #1;
    checkOutput();
  endtask

  initial begin
    en = 0; stall = 0; flush = 0; halt = 0; pc_4_in = '0; inst_in = '0;
    en4 = 0; stall4 = 0; flush4 = 0; halt4 = 0; pc_4_in4 = '0; inst_in4 = '0;
    rst = 1'b1;
    #3;
    sb.push_back(mkExp(10'h0, 32'h0, 0, 0, 0, 0, "reset"));
    checkOutput();
    checkValue("dut4_reset.stall_cnt", {28'd0, stall_cnt4}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    vecs.push_back(mkVec(1,0,0,0, 10'h004, 32'h2008_0005, mkExp(10'h004, 32'h2008_0005, 1, 0, 0, 0, "load1")));
    for (int i = 1; i <= 3; i++)
      vecs.push_back(mkVec(1,1,0,0, 10'h008, 32'h0000_000C,
                           mkExp(10'h004, 32'h2008_0005, 1, 0, 16'(i), 0, $sformatf("stall%0d", i))));
    vecs.push_back(mkVec(1,1,1,0, 10'h008, 32'h0000_000C, mkExp(10'h0, 32'h0, 0, 0, 3, 1, "flush_stall")));
    vecs.push_back(mkVec(1,0,0,0, 10'h008, 32'h0000_000C, mkExp(10'h008, 32'h0000_000C, 1, 0, 3, 1, "load2")));
    for (int i = 1; i <= 4; i++)
      vecs.push_back(mkVec(0,1,1,1, 10'h00C, 32'hDEAD_BEEF,
                           mkExp(10'h008, 32'h0000_000C, 1, 0, 3, 1, $sformatf("en_off%0d", i))));
    vecs.push_back(mkVec(1,0,0,0, 10'h010, 32'h0000_1234, mkExp(10'h010, 32'h0000_1234, 1, 0, 3, 1, "load3")));
    vecs.push_back(mkVec(1,0,1,1, 10'h014, 32'h1111_1111, mkExp(10'h010, 32'h0000_1234, 1, 1, 3, 1, "halt_flush")));
    for (int i = 1; i <= 5; i++)
      vecs.push_back(mkVec(1,0,0,0, 10'(10'h018 + 4*i), 32'hA000_0000 + i,
                           mkExp(10'h010, 32'h0000_1234, 1, 1, 3, 1, $sformatf("halted_load%0d", i))));
    vecs.push_back(mkVec(1,1,1,0, 10'h3FC, 32'hFFFF_FFFF, mkExp(10'h010, 32'h0000_1234, 1, 1, 3, 1, "halted_flush")));

    foreach (vecs[i]) runStep(vecs[i]);

    // Asynchronous reset pulse well away from any clock edge.
    #1;
    rst = 1'b1;
    #1;
    sb.push_back(mkExp(10'h0, 32'h0, 0, 0, 0, 0, "mid_reset"));
    checkOutput();
    #1;
    rst = 1'b0;

    runStep(mkVec(1,0,1,0, 10'h020, 32'h2222_2222, mkExp(10'h0, 32'h0, 0, 0, 0, 1, "empty_flush")));
    runStep(mkVec(1,1,0,0, 10'h024, 32'h3333_3333, mkExp(10'h0, 32'h0, 0, 0, 1, 1, "empty_stall")));
    runStep(mkVec(1,1,1,1, 10'h028, 32'h4444_4444, mkExp(10'h0, 32'h0, 0, 1, 1, 1, "empty_halt")));
    runStep(mkVec(1,0,0,0, 10'h02C, 32'h5555_5555, mkExp(10'h0, 32'h0, 0, 1, 1, 1, "empty_halt_load")));

    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      en4 = 1; stall4 = 1; flush4 = 0;
      @(posedge clk);
      #1;
      checkValue($sformatf("sat_stall%0d", k), {28'd0, stall_cnt4}, (k > 15) ? 32'd15 : 32'(k));
    end
    for (int k = 1; k <= 18; k++) begin
      @(negedge clk);
      stall4 = 0; flush4 = 1;
      @(posedge clk);
      #1;
      checkValue($sformatf("sat_flush%0d", k), {28'd0, flush_cnt4}, (k > 15) ? 32'd15 : 32'(k));
    end
    checkValue("sat_stall_hold", {28'd0, stall_cnt4}, 32'd15);
    checkValue("sat_valid", {31'd0, valid_out4}, 32'd0);
    @(negedge clk);
    en4 = 0; flush4 = 0;

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/syn_pipe_if_id.md
Name: syn_pipe_if_id

Overview:
- IF/ID pipeline register for the five-stage CPU core.
- Captures `pc_4` and the instruction word from the fetch stage (PC plus instruction memory) and presents them to the decode stage (decoder, control unit, register file read).
- Supports hazard stall (hold), branch/jump flush (bubble insertion) and a sticky halt freeze.
- Keeps saturating stall and flush counters for debug and performance readout.

Parameters:
- AddrBit, 10, width of the word-address PC and `pc_4` (equals the instruction-memory address width).
- CntBit, 16, width of each saturating event counter.
- NopInst, 32'h0000_0000, instruction word inserted as a bubble (`sll $0,$0,0`).

Ports:
- clk  in  1  core clock; all state updates on its rising edge.
- rst  in  1  asynchronous, active-high reset.
- en  in  1  global step enable; when low, all state holds.
- stall  in  1  hazard stall from the hazard unit; hold the current contents.
- flush  in  1  taken jump or branch from the EX-stage WTG; replace the contents with a bubble.
- halt  in  1  syscall halt seen downstream; freeze the register permanently until reset.
- pc_4_in  in  AddrBit  `pc_4` from the PC unit.
- inst_in  in  32  instruction word from instruction memory.
- pc_4_out  out  AddrBit  registered `pc_4` to decode.
- inst_out  out  32  registered instruction to decode.
- valid_out  out  1  1 when `inst_out` is a real fetched instruction, 0 for a bubble.
- halted_out  out  1  1 while in the HALT state.
- stall_cnt  out  CntBit  count of stall-hold cycles.
- flush_cnt  out  CntBit  count of flush events.

Behaviour:
- Reset (asynchronous, immediate on `rst`=1, also mid-operation):
  - `pc_4_out`=0, `inst_out`=NopInst, `valid_out`=0, `halted_out`=0.
  - Both counters are 0; state is EMPTY.
- States:
  - EMPTY: after reset; holds a bubble with `valid_out`=0.
  - RUN: a valid instruction or bubble is in flight.
  - HALT: frozen.
- Evaluation each rising edge with `en`=1, in priority order halt > flush > stall > load:
  - halt=1 (any state except HALT): go to HALT, set `halted_out`=1. Data outputs hold. No counter changes, even if flush or stall are also high.
  - flush=1: `inst_out`<=NopInst, `pc_4_out`<=0, `valid_out`<=0, `flush_cnt`+1. State goes to RUN (or stays EMPTY if it was EMPTY). Flush wins over a simultaneous stall; `stall_cnt` is not incremented.
  - stall=1: all data outputs hold, `stall_cnt`+1. In EMPTY, the stall still counts and the state stays EMPTY.
  - otherwise (load): `pc_4_out`<=`pc_4_in`, `inst_out`<=`inst_in`, `valid_out`<=1, state goes to RUN.
- `en`=0: no state, output or counter change, regardless of halt, flush or stall.
- HALT: absorbing until `rst`. All inputs are ignored and counters freeze.
- Counters saturate at 2^CntBit-1; they never wrap to 0.
- Latency: one cycle from `pc_4_in`/`inst_in` to the outputs on a load edge. No combinational path from any input to any output.
- Outputs are driven only from flops.

Test Plan:
- Reset, then load `pc_4_in`=10'h004, `inst_in`=32'h2008_0005 for one edge with `en`=1 -> next cycle `pc_4_out`=10'h004, `inst_out`=32'h2008_0005, `valid_out`=1.
- Assert `stall` for 3 edges while the inputs change to 10'h008/32'h0000_000C -> outputs stay 10'h004/32'h2008_0005, `stall_cnt`=3.
- Assert `flush` and `stall` together for 1 edge -> `inst_out`=0, `pc_4_out`=0, `valid_out`=0, `flush_cnt`=1, `stall_cnt` unchanged at 3.
- Assert `halt` with `flush`=1 on the same edge -> `halted_out`=1, outputs and counters unchanged. 5 further load edges cause no change. Pulse `rst` mid-cycle -> all outputs return to reset values immediately, without waiting for a clock edge.
- Set CntBit=4 and hold `stall` for 20 edges -> `stall_cnt`=4'hF, no wrap.
- Set `en`=0 with `flush`=1 and `halt`=1 for 4 edges -> no state or counter change. Then set `en`=1 with only a load -> normal capture.
